// File: rtl/seq_det_pkg.sv
// Shared constants and mode encoding for the parameterised sequence detector.
package seq_det_pkg;

  localparam int         PAT_W_DEF   = 8;
  localparam int         CNT_W_DEF   = 16;
  localparam logic [7:0] PAT_RST_DEF = 8'b0000_1011;
  localparam int         LEN_RST_DEF = 4;

  // Output timing: Mealy drives dout straight from the hit logic,
  // Moore drives it from a register one cycle later.
  typedef enum logic {
    MODE_MEALY = 1'b0,
    MODE_MOORE = 1'b1
  } mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sat flags the all-ones value.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign sat   = &count_q;
  assign count = count_q;

  // Next count: clear wins, otherwise step up unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern/length, overlap
// control, Mealy/Moore output selection and a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               LEN_RST = LEN_RST_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
  input  logic                         overlap_en,
  input  logic                         moore_mode,
  output logic                         dout,
  output logic [CNT_W-1:0]             match_count,
  output logic                         count_sat
);

  localparam int LEN_W = $clog2(PAT_W+1);

  // Lengths outside 2..PAT_W are pulled to the nearest legal value when latched.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(2)) begin
      return LEN_W'(2);
    end else if (l > LEN_W'(PAT_W)) begin
      return LEN_W'(PAT_W);
    end else begin
      return l;
    end
  endfunction

  logic [PAT_W-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0] len_q,  len_d;
  logic             overlap_q, overlap_d;
  mode_e            mode_q, mode_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             dout_q, dout_d;

  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] mask;
  logic             pat_eq;
  logic             fill_ok;
  logic             hit;

  // History as it would look with the current bit appended.
  assign shifted = {hist_q[PAT_W-2:0], din};

  // Only the low len bits of the window take part in the comparison.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign mask[gi] = (len_q > LEN_W'(gi));
  end

  assign pat_eq  = (((shifted ^ pat_q) & mask) == '0);
  assign fill_ok = (fill_q >= (len_q - LEN_W'(1)));
  // Reset and cfg_load both suppress any match on their edge.
  assign hit     = din_valid & ~cfg_load & ~reset & fill_ok & pat_eq;

  assign dout = ~reset & ((mode_q == MODE_MOORE) ? dout_q : hit);

  // Next-state: cfg_load reloads config and clears the stream; otherwise shift on valid.
  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    mode_d    = mode_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = hit;
    if (cfg_load) begin
      pat_d     = pattern;
      len_d     = clamp_len(pat_len);
      overlap_d = overlap_en;
      mode_d    = mode_e'(moore_mode);
      hist_d    = '0;
      fill_d    = '0;
      dout_d    = 1'b0;
    end else if (din_valid) begin
      hist_d = shifted;
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(PAT_W)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // State registers; reset restores the power-on configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q     <= PAT_RST;
      len_q     <= clamp_len(LEN_W'(LEN_RST));
      overlap_q <= 1'b1;
      mode_q    <= MODE_MEALY;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      mode_q    <= mode_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (hit),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_seq_detect_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        din_valid;
  logic        cfg_load;
  logic [7:0]  pattern;
  logic [3:0]  pat_len;
  logic        overlap_en;
  logic        moore_mode;
  logic        dout_a, sat_a, dout_b, sat_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .moore_mode(moore_mode),
    .dout(dout_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  seq_detect_param #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap_en(overlap_en), .moore_mode(moore_mode),
    .dout(dout_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: received bits since the last clear, oldest first.
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl, m_moore, m_dout_reg;
  bit       m_bits[$];
  int       m_cnt_a, m_cnt_b;

  // Expected and observed values for the step just taken.
  bit       e_dout, e_sat_a, e_sat_b;
  int       e_cnt_a, e_cnt_b;
  logic        o_dout, o_dout_b, o_sat_a, o_sat_b;
  logic [15:0] o_cnt_a;
  logic [1:0]  o_cnt_b;

  function automatic int clamp(input logic [3:0] pl);
    if (pl < 2) return 2;
    if (pl > 8) return 8;
    return int'(pl);
  endfunction

  // A match: the last len received bits (including this one) spell the pattern MSB-first.
  function automatic bit model_hit(input bit v, input bit d, input bit cl, input bit rs);
    int n;
    bit b;
    if (!v || cl || rs) return 1'b0;
    n = m_bits.size();
    if (n < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == m_len - 1) ? d : m_bits[n - (m_len - 1) + k];
      if (b != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive inputs, predict outputs, sample before the next edge, advance the model.
  task automatic step(input bit v, input bit d, input bit cl, input bit rs);
    bit h;
    @(posedge clk);
    #1;
    din_valid = v; din = d; cfg_load = cl; reset = rs;
    h       = model_hit(v, d, cl, rs);
    e_dout  = rs ? 1'b0 : (m_moore ? m_dout_reg : h);
    e_cnt_a = m_cnt_a;
    e_cnt_b = m_cnt_b;
    e_sat_a = (m_cnt_a == 65535);
    e_sat_b = (m_cnt_b == 3);
    #3;
    o_dout = dout_a; o_dout_b = dout_b;
    o_cnt_a = cnt_a; o_cnt_b = cnt_b;
    o_sat_a = sat_a; o_sat_b = sat_b;
    if (rs) begin
      m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1; m_moore = 1'b0;
      m_bits.delete(); m_cnt_a = 0; m_cnt_b = 0; m_dout_reg = 1'b0;
    end else if (cl) begin
      m_pat = pattern; m_len = clamp(pat_len); m_ovl = overlap_en; m_moore = moore_mode;
      m_bits.delete(); m_cnt_a = 0; m_cnt_b = 0; m_dout_reg = 1'b0;
    end else begin
      m_dout_reg = h;
      if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        if (h) begin
          if (m_cnt_a < 65535) m_cnt_a++;
          if (m_cnt_b < 3) m_cnt_b++;
          if (!m_ovl) m_bits.delete();
        end
      end
    end
  endtask

  task automatic load_cfg(input bit [7:0] p, input bit [3:0] pl, input bit ov, input bit mo);
    pattern = p; pat_len = pl; overlap_en = ov; moore_mode = mo;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (o_dout !== 1'b0) begin
        errors++; $display("FAIL reset_dout: got %b want 0", o_dout);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cnt_a !== 16'd0 || o_sat_a !== 1'b0 || o_dout !== 1'b0) begin
      errors++; $display("FAIL reset_state: cnt=%0d sat=%b dout=%b want 0/0/0", o_cnt_a, o_sat_a, o_dout);
    end
    checks++;
    if (o_cnt_b !== 2'd0 || o_sat_b !== 1'b0) begin
      errors++; $display("FAIL reset_state_c2: cnt=%0d sat=%b want 0/0", o_cnt_b, o_sat_b);
    end
    $display("test_reset done");
  endtask

  task automatic test_mealy_overlap;
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit want[7]   = '{0, 0, 0, 1, 0, 0, 1};
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== want[i]) begin
        errors++; $display("FAIL overlap_dout bit%0d: got %b want %b", i + 1, o_dout, want[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cnt_a !== 16'd2) begin
      errors++; $display("FAIL overlap_count: got %0d want 2", o_cnt_a);
    end
    $display("test_mealy_overlap count=%0d", o_cnt_a);
  endtask

  task automatic test_non_overlap;
    bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit want[7]   = '{0, 0, 0, 1, 0, 0, 0};
    load_cfg(8'h0B, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== want[i]) begin
        errors++; $display("FAIL nonoverlap_dout bit%0d: got %b want %b", i + 1, o_dout, want[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cnt_a !== 16'd1) begin
      errors++; $display("FAIL nonoverlap_count: got %0d want 1", o_cnt_a);
    end
    $display("test_non_overlap count=%0d", o_cnt_a);
  endtask

  task automatic test_moore;
    bit stream[4] = '{1, 0, 1, 1};
    load_cfg(8'h0B, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, stream[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== 1'b0) begin
        errors++; $display("FAIL moore_early bit%0d: got %b want 0", i + 1, o_dout);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_dout !== 1'b1) begin
      errors++; $display("FAIL moore_pulse: got %b want 1", o_dout);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_dout !== 1'b0) begin
      errors++; $display("FAIL moore_pulse_end: got %b want 0", o_dout);
    end
    // Reset arriving while the registered pulse would show must hide it.
    load_cfg(8'h0B, 4'd4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, stream[i], 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (o_dout !== 1'b0) begin
      errors++; $display("FAIL moore_reset_hold: got %b want 0", o_dout);
    end
    $display("test_moore done");
  endtask

  task automatic test_gaps;
    int hits = 0;
    bit [7:0] p = 8'hA5;
    load_cfg(8'hA5, 4'd8, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      int g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        step(1'b0, 1'($urandom), 1'b0, 1'b0);
        checks++;
        if (o_dout !== 1'b0) begin
          errors++; $display("FAIL gap_dout: got %b want 0", o_dout);
        end
      end
      step(1'b1, p[i], 1'b0, 1'b0);
      if (o_dout === 1'b1) hits++;
      checks++;
      if (o_dout !== e_dout) begin
        errors++; $display("FAIL gap_bit%0d: got %b want %b", 7 - i, o_dout, e_dout);
      end
    end
    checks++;
    if (hits != 1) begin
      errors++; $display("FAIL gap_hits: got %0d want 1", hits);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
      checks++;
      if (o_dout !== 1'b0) begin
        errors++; $display("FAIL novalid_dout: got %b want 0", o_dout);
      end
    end
    checks++;
    if (o_cnt_a !== 16'd1) begin
      errors++; $display("FAIL gap_count: got %0d want 1", o_cnt_a);
    end
    $display("test_gaps hits=%0d count=%0d", hits, o_cnt_a);
  endtask

  task automatic test_len_clamp;
    bit s2[5] = '{1, 0, 0, 1, 0};
    bit w2[5] = '{0, 1, 0, 0, 1};
    bit [7:0] p = 8'hA5;
    load_cfg(8'hFE, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s2[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== w2[i]) begin
        errors++; $display("FAIL len0_dout bit%0d: got %b want %b", i + 1, o_dout, w2[i]);
      end
    end
    load_cfg(8'hA5, 4'd15, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, p[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== (i == 0)) begin
        errors++; $display("FAIL len15_dout bit%0d: got %b want %b", 8 - i, o_dout, (i == 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cnt_a !== 16'd1) begin
      errors++; $display("FAIL len15_count: got %0d want 1", o_cnt_a);
    end
    $display("test_len_clamp done");
  endtask

  task automatic test_saturation;
    load_cfg(8'h03, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (o_dout_b !== e_dout) begin
        errors++; $display("FAIL sat_dout bit%0d: got %b want %b", i + 1, o_dout_b, e_dout);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (o_cnt_b !== 2'd3 || o_sat_b !== 1'b1) begin
      errors++; $display("FAIL sat_c2: cnt=%0d sat=%b want 3/1", o_cnt_b, o_sat_b);
    end
    checks++;
    if (o_cnt_a !== 16'd4 || o_sat_a !== 1'b0) begin
      errors++; $display("FAIL sat_wide: cnt=%0d sat=%b want 4/0", o_cnt_a, o_sat_a);
    end
    $display("test_saturation cnt2=%0d cnt16=%0d", o_cnt_b, o_cnt_a);
  endtask

  task automatic test_priority;
    bit tail[7] = '{0, 1, 1, 1, 0, 1, 1};
    bit twant[7] = '{0, 0, 0, 0, 0, 0, 1};
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (o_dout !== 1'b0) begin
      errors++; $display("FAIL prio_reset_same: got %b want 0", o_dout);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_dout !== 1'b0) begin
      errors++; $display("FAIL prio_after_reset: got %b want 0", o_dout);
    end
    pattern = 8'h0B; pat_len = 4'd4; overlap_en = 1'b1; moore_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_dout !== 1'b0) begin
      errors++; $display("FAIL prio_cfg_same: got %b want 0", o_dout);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, tail[i], 1'b0, 1'b0);
      checks++;
      if (o_dout !== twant[i]) begin
        errors++; $display("FAIL prio_cfg_tail bit%0d: got %b want %b", i + 1, o_dout, twant[i]);
      end
    end
    $display("test_priority done");
  endtask

  task automatic test_random;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        pattern = 8'($urandom); pat_len = 4'($urandom);
        overlap_en = 1'($urandom); moore_mode = 1'($urandom);
        step(1'($urandom), 1'($urandom), 1'b1, 1'b0);
      end else if (r < 4) begin
        step(1'($urandom), 1'($urandom), 1'b0, 1'b1);
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, 1'b0);
      end
      checks++;
      if (o_dout !== e_dout || o_dout_b !== e_dout) begin
        errors++; bad++;
        $display("FAIL rand_dout cyc%0d: got %b/%b want %b", i, o_dout, o_dout_b, e_dout);
      end
      checks++;
      if (o_cnt_a !== 16'(e_cnt_a) || o_cnt_b !== 2'(e_cnt_b) ||
          o_sat_a !== e_sat_a || o_sat_b !== e_sat_b) begin
        errors++; bad++;
        $display("FAIL rand_count cyc%0d: got %0d/%0d sat %b/%b want %0d/%0d sat %b/%b",
                 i, o_cnt_a, o_cnt_b, o_sat_a, o_sat_b, e_cnt_a, e_cnt_b, e_sat_a, e_sat_b);
      end
    end
    $display("test_random mismatches=%0d", bad);
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    pattern = 8'h00; pat_len = 4'd0; overlap_en = 1'b1; moore_mode = 1'b0;
    m_pat = 8'h0B; m_len = 4; m_ovl = 1'b1; m_moore = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0; m_dout_reg = 1'b0;
    test_reset();
    test_mealy_overlap();
    test_non_overlap();
    test_moore();
    test_gaps();
    test_len_clamp();
    test_saturation();
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
